// File: rtl/ecg_sample_writer_pkg.sv
// Shared types and constants for the ECG sample capture path (package ecg_pkg).
package ecg_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 12;

    localparam logic [7:0] OVR_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        WRITING = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == OVR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ecg_sample_writer_edge.sv
// Rising-edge detector for a slow strobe; the history reset value decides whether
// a strobe already high when reset is released counts as an edge.
module ecg_strobe_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic rise
);

    logic strobe_q;

    always_ff @(posedge clk) begin
        if (!rst_n) strobe_q <= RST_VAL;
        else        strobe_q <= strobe;
    end

    assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/ecg_sample_writer.sv
// Captures strobed ECG samples into sequential sample-RAM addresses.
// Define ECG_WRITER_WRAP_EN for circular capture with a sticky 'wrapped' flag.
module ecg_sample_writer
    import ecg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_strobe,
    input  logic [DATA_W-1:0] sample_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [ADDR_W:0]   sample_count,
    output logic              busy,
    output logic              done,
`ifdef ECG_WRITER_WRAP_EN
    output logic              wrapped,
`endif
    output logic [7:0]        overrun_cnt
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              rise;

    ecg_strobe_edge #(.RST_VAL(1'b1)) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (sample_strobe),
        .rise   (rise)
    );

    assign busy = (state == ARMED) || (state == WRITING);
    assign done = (state == DONE);

    // A rise registers the write directly, so it appears one cycle later and
    // survives an abort that arrives in that following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            sample_count <= '0;
            overrun_cnt  <= '0;
`ifdef ECG_WRITER_WRAP_EN
            wrapped      <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
`ifdef ECG_WRITER_WRAP_EN
            if (abort) wrapped <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state        <= ARMED;
                        wr_ptr       <= '0;
                        sample_count <= '0;
                        overrun_cnt  <= '0;
`ifdef ECG_WRITER_WRAP_EN
                        wrapped      <= 1'b0;
`endif
                    end
                end
                ARMED: begin
                    // Wait for strobe low so a half-seen sample is never captured.
                    if (abort)               state <= IDLE;
                    else if (!sample_strobe) state <= WRITING;
                end
                WRITING: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (rise) begin
                        mem_we   <= 1'b1;
                        mem_addr <= wr_ptr;
                        mem_din  <= sample_data;
`ifdef ECG_WRITER_WRAP_EN
                        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                        if (sample_count == DEPTH_C) wrapped <= 1'b1;
                        else                         sample_count <= sample_count + 1'b1;
`else
                        wr_ptr       <= wr_ptr + 1'b1;
                        sample_count <= sample_count + 1'b1;
                        if (sample_count == DEPTH_C - 1'b1) state <= DONE;
`endif
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (start) begin
                        state        <= ARMED;
                        wr_ptr       <= '0;
                        sample_count <= '0;
                        overrun_cnt  <= '0;
                    end else if (rise) begin
                        overrun_cnt <= sat_inc8(overrun_cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecg_sample_writer.sv
// Directed bench for ecg_sample_writer (DEPTH=8) with a write scoreboard; honours ECG_WRITER_WRAP_EN.
module tb_ecg_sample_writer;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 8;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              sample_strobe = 1'b1;
    logic [DATA_W-1:0] sample_data = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [ADDR_W:0]   sample_count;
    logic              busy;
    logic              done;
    logic [7:0]        overrun_cnt;
`ifdef ECG_WRITER_WRAP_EN
    logic              wrapped;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t mon_e;
    logic prev_we = 1'b0;

    ecg_sample_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .sample_strobe (sample_strobe),
        .sample_data   (sample_data),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .sample_count  (sample_count),
        .busy          (busy),
        .done          (done),
`ifdef ECG_WRITER_WRAP_EN
        .wrapped       (wrapped),
`endif
        .overrun_cnt   (overrun_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write must match the oldest expected entry, including its cycle.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 32'(mem_we), 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(mem_din), 32'(mon_e.data));
                chk("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
            if (prev_we) chk("we_consecutive", 32'(mem_we & prev_we), 32'd0);
        end
        prev_we = mem_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rise(input logic [DATA_W-1:0] d, input bit expect_wr, input logic [ADDR_W-1:0] a);
        exp_t e;
        sample_strobe = 1'b1;
        sample_data   = d;
        if (expect_wr) begin
            e.addr = a; e.data = d; e.cyc = cyc + 1;
            q.push_back(e);
        end
        tick();
        tick();
        sample_strobe = 1'b0;
        tick();
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
        sample_strobe = 1'b0;
        tick();
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        exp_t e;
        // Reset with strobe high
        rst_n = 1'b0; sample_strobe = 1'b1;
        tick(); tick();
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_din", 32'(mem_din), 0);
        chk("rst_count", 32'(sample_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovr", 32'(overrun_cnt), 0);
        rst_n = 1'b1;
        tick();

        // Strobe held high through ARMED must not capture
        start = 1'b1; tick(); start = 1'b0;
        chk("armed_busy", 32'(busy), 1);
        repeat (10) tick();
        chk("armed_hold_count", 32'(sample_count), 0);
        chk("armed_hold_busy", 32'(busy), 1);
        sample_strobe = 1'b0; tick();
        rise(12'hA5C, 1'b1, 12'd0);
        chk("first_count", 32'(sample_count), 1);
        pulse_abort();
        chk("abort1_busy", 32'(busy), 0);
        chk("abort1_count", 32'(sample_count), 1);

`ifndef ECG_WRITER_WRAP_EN
        // Full single-shot run then overrun
        arm();
        chk("run_count0", 32'(sample_count), 0);
        for (int i = 1; i <= DEPTH; i++) rise(DATA_W'(i), 1'b1, ADDR_W'(i - 1));
        chk("full_count", 32'(sample_count), DEPTH);
        chk("full_done", 32'(done), 1);
        chk("full_busy", 32'(busy), 0);
        for (int i = 0; i < 300; i++) rise(12'hFFF, 1'b0, 12'd0);
        chk("ovr_sat", 32'(overrun_cnt), 255);
        chk("ovr_count_hold", 32'(sample_count), DEPTH);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_ovr", 32'(overrun_cnt), 0);
        chk("restart_count", 32'(sample_count), 0);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_done", 32'(done), 0);
        pulse_abort();
`endif

        // Abort coincident with the 4th rise drops it
        arm();
        for (int i = 0; i < 3; i++) rise(DATA_W'(12'h100 + i), 1'b1, ADDR_W'(i));
        sample_strobe = 1'b1; sample_data = 12'h1FF; abort = 1'b1;
        tick();
        abort = 1'b0; tick();
        sample_strobe = 1'b0; tick();
        chk("abortA_busy", 32'(busy), 0);
        chk("abortA_count", 32'(sample_count), 3);

        // Abort one cycle after the 4th rise: the write still lands
        arm();
        for (int i = 0; i < 3; i++) rise(DATA_W'(12'h200 + i), 1'b1, ADDR_W'(i));
        sample_strobe = 1'b1; sample_data = 12'h2AB;
        e.addr = 12'd3; e.data = 12'h2AB; e.cyc = cyc + 1;
        q.push_back(e);
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        sample_strobe = 1'b0; tick();
        chk("abortB_busy", 32'(busy), 0);
        chk("abortB_count", 32'(sample_count), 4);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 0);
        chk("sa_done", 32'(done), 0);
        chk("sa_count", 32'(sample_count), 4);

        // Reset mid-run, coincident with a rise
        arm();
        for (int i = 0; i < 5; i++) rise(DATA_W'(12'h400 + i), 1'b1, ADDR_W'(i));
        chk("pre_rst_count", 32'(sample_count), 5);
        rst_n = 1'b0; sample_strobe = 1'b1; sample_data = 12'h4FF;
        tick();
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        chk("mid_rst_din", 32'(mem_din), 0);
        chk("mid_rst_count", 32'(sample_count), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        rst_n = 1'b1; sample_strobe = 1'b0;
        tick();

`ifdef ECG_WRITER_WRAP_EN
        // Circular capture: 10 rises over 8 addresses
        arm();
        for (int i = 0; i < 10; i++) begin
            rise(DATA_W'(12'h300 + i), 1'b1, ADDR_W'(i % DEPTH));
            if (i == 7) begin
                chk("wrap_pre_flag", 32'(wrapped), 0);
                chk("wrap_pre_count", 32'(sample_count), DEPTH);
            end
            if (i == 8) chk("wrap_flag", 32'(wrapped), 1);
        end
        chk("wrap_count_sat", 32'(sample_count), DEPTH);
        chk("wrap_done", 32'(done), 0);
        chk("wrap_busy", 32'(busy), 1);
        pulse_abort();
        chk("wrap_abort_flag", 32'(wrapped), 0);
        chk("wrap_abort_busy", 32'(busy), 0);
`endif

        repeat (4) tick();
        chk("queue_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecg_sample_writer.md
Name: ecg_sample_writer

Overview:
- Write-side counterpart of the ECG sample fetch path: it captures 12-bit ECG samples presented with a slow sample strobe.
- Each captured sample is written to sequential addresses of an external sample RAM, starting at 0.
- It sits between the ADC/receive front end and the sample memory that the fetch unit later reads.
- It tracks fill level and flags completion and overrun.

Parameters:
ADDR_W, 12, sample RAM address width
DATA_W, 12, sample width
DEPTH, 4096, number of samples per capture run (must be ≤ 2**ADDR_W)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins a capture run from IDLE or DONE
abort  input  1  one-cycle pulse; ends the run and returns to IDLE
sample_strobe  input  1  slow level strobe; each rising edge marks one valid sample
sample_data  input  DATA_W  sample value, stable while sample_strobe is high
mem_we  output  1  one-cycle RAM write enable
mem_addr  output  ADDR_W  RAM write address
mem_din  output  DATA_W  RAM write data
sample_count  output  ADDR_W+1  samples written in the current run
busy  output  1  high in ARMED or WRITING
done  output  1  high in DONE
overrun_cnt  output  8  saturating count of strobe edges dropped while in DONE

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE; mem_we, mem_addr, mem_din, sample_count, busy, done, overrun_cnt all 0.
  - The edge-detect history register resets to 1, so a strobe already high at reset release is not an edge.
- Edge detect: rise = sample_strobe & ~strobe_q; strobe_q <= sample_strobe every cycle.
- States:
  - IDLE: start -> ARMED; clears sample_count, write pointer and overrun_cnt.
  - ARMED: waits until sample_strobe is sampled low, so a partial sample is never captured; then -> WRITING.
  - WRITING: on rise, the next cycle drives mem_we=1, mem_addr=wr_ptr and mem_din=sample_data (as captured in the rise cycle). In that same cycle wr_ptr and sample_count increment.
    - Latency: rise in cycle N -> write in cycle N+1.
    - When the write that makes sample_count==DEPTH issues, the next state is DONE.
  - DONE: done=1; further rises increment overrun_cnt, saturating at 255, and never write. start -> ARMED, which clears the counters.
- abort in any non-IDLE state -> IDLE next cycle.
  - A pending write whose rise occurred in the previous cycle still completes.
  - A rise coincident with abort is dropped.
  - sample_count holds its value after abort.
- Simultaneous events:
  - start with rise in IDLE: the rise is ignored.
  - start and abort together: abort wins.
  - start while busy: ignored.
- mem_we is never high for two consecutive cycles, because the rise detector cannot fire on adjacent cycles.
- mem_addr and mem_din hold their last values when mem_we=0.
- Reset mid-run drops any pending write and returns everything to reset values.

Optional Feature:
- Macro: ECG_WRITER_WRAP_EN.
- Defined (circular capture):
  - After address DEPTH-1 the pointer wraps to 0 and the block stays in WRITING; DONE is unreachable.
  - sample_count saturates at DEPTH.
  - Extra output port wrapped (1 bit) goes high sticky on the first wrap; it is cleared by start, abort or reset.
  - Only abort exits the run.
- Undefined: single-shot behaviour as above; the wrapped port does not exist.

Decomposition:
- Shared package ecg_pkg holds:
  - ADDR_W/DATA_W defaults;
  - the state typedef (IDLE, ARMED, WRITING, DONE) with 2-bit encoding;
  - the OVR_MAX constant (255).
- One natural sub-module: ecg_strobe_edge, the rise detector with configurable history reset value. It is reusable by the fetch side for its clk_out strobe.

Test Plan:
- Reset with sample_strobe high, then start, then strobe held high for 10 cycles -> no mem_we. Strobe low then high -> ARMED->WRITING; first write is addr 0, data as driven (e.g. 12'hA5C).
- DEPTH=8, start, 8 strobe rises with data 1..8 -> writes to addr 0..7 in order, each 1 cycle after its rise. sample_count=8, done=1, busy=0.
- In DONE apply 300 more rises -> overrun_cnt=255 and no mem_we. Then start -> overrun_cnt=0, sample_count=0, state ARMED.
- After 3 writes, abort coincident with the 4th rise -> no 4th write, state IDLE, sample_count=3. Repeat with abort one cycle after the rise -> the 4th write to addr 3 completes.
- start and abort same cycle in IDLE -> stays IDLE. Assert rst_n low mid-run after 5 writes -> all outputs 0 the next cycle.
- With ECG_WRITER_WRAP_EN, DEPTH=8, 10 rises -> addresses 0..7,0,1; wrapped=1 from the 9th write; done stays 0; sample_count=8.
